// File: rtl/neighbor_id_responder.sv
// Neighbor-ID responder: accepts one granted request, looks up the node's {base,num}
// descriptor and streams packed pairs of neighbor IDs from the pair SRAM, framed by sos/eos.
module neighbor_id_responder #(
   parameter int NODE_W  = 7,
   parameter int TAG_W   = 2,
   parameter int MAX_DEG = 14,
   parameter int NUM_W   = 4,
   parameter int ADDR_W  = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   req_valid_i,
   input  logic [TAG_W-1:0]       req_pe_tag_i,
   input  logic [NODE_W-1:0]      req_node_id_i,
   output logic                   req_ready_o,
   output logic                   out_valid_o,
   output logic [TAG_W-1:0]       out_pe_tag_o,
   output logic                   out_sos_o,
   output logic                   out_eos_o,
   output logic [2*NODE_W-1:0]    out_ids_o,
   output logic [NUM_W-1:0]       out_num_o,
   input  logic                   cfg_we_i,
   input  logic                   cfg_sel_i,
   input  logic [ADDR_W-1:0]      cfg_addr_i,
   input  logic [((2*NODE_W > ADDR_W+NUM_W) ? 2*NODE_W : ADDR_W+NUM_W)-1:0] cfg_wdata_i,
   output logic                   cfg_err_o
);
   localparam int PAIR_W = 2 * NODE_W;
   localparam int DESC_W = ADDR_W + NUM_W;
   localparam int BEAT_W = $clog2((MAX_DEG + 1) / 2 + 1);

   typedef enum logic [1:0] {IDLE, LOOKUP, FETCH} state_t;
   state_t state_q, state_d;

   logic [DESC_W-1:0] desc_mem [2**NODE_W];
   logic [PAIR_W-1:0] pair_mem [2**ADDR_W];
   logic [DESC_W-1:0] desc_rdata_q;
   logic [PAIR_W-1:0] pair_rdata_q;

   logic [TAG_W-1:0]  tag_q, tag_d;
   logic [NUM_W-1:0]  num_q, num_d;
   logic [BEAT_W-1:0] beats_q, beats_d, idx_q, idx_d;
   logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;

   logic                out_valid_q, out_valid_d, out_sos_q, out_sos_d, out_eos_q, out_eos_d;
   logic [TAG_W-1:0]    out_tag_q, out_tag_d;
   logic [NUM_W-1:0]    out_num_q, out_num_d;
   logic [PAIR_W-1:0]   out_ids_q, out_ids_d;
   logic                cfg_err_q, cfg_err_d;

   logic desc_re, desc_we, pair_re, pair_we, last_beat;
   logic [ADDR_W-1:0] pair_raddr, lk_base;
   logic [NUM_W-1:0]  lk_num;
   logic [NUM_W:0]    lk_half;
   logic [BEAT_W-1:0] lk_beats;
   logic [1:0]        half_ok;
   logic [PAIR_W-1:0] beat_ids;

   // Descriptor decode: clamp the count, then B = max(1, ceil(num/2))
   assign lk_base  = desc_rdata_q[DESC_W-1:NUM_W];
   assign lk_num   = (desc_rdata_q[NUM_W-1:0] > NUM_W'(MAX_DEG)) ? NUM_W'(MAX_DEG)
                                                                 : desc_rdata_q[NUM_W-1:0];
   assign lk_half  = ({1'b0, lk_num} + 1'b1) >> 1;
   assign lk_beats = (lk_num == '0) ? BEAT_W'(1) : lk_half[BEAT_W-1:0];
   assign last_beat = (idx_q == beats_q - 1'b1);

   // Each half of a beat is kept only if its neighbor index is below num
   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_half
         logic [NUM_W:0] pos;
         assign pos = {{(NUM_W - BEAT_W){1'b0}}, idx_q, 1'(gi)};
         assign half_ok[gi] = pos < {1'b0, num_q};
         assign beat_ids[gi*NODE_W +: NODE_W] =
            half_ok[gi] ? pair_rdata_q[gi*NODE_W +: NODE_W] : '0;
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (desc_we) desc_mem[cfg_addr_i[NODE_W-1:0]] <= cfg_wdata_i[DESC_W-1:0];
      if (desc_re) desc_rdata_q <= desc_mem[req_node_id_i];
   end

   always_ff @(posedge clk) begin
      if (pair_we) pair_mem[cfg_addr_i] <= cfg_wdata_i[PAIR_W-1:0];
      if (pair_re) pair_rdata_q <= pair_mem[pair_raddr];
   end

   always_ff @(posedge clk) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (req_valid_i) state_d = LOOKUP;
         LOOKUP:  state_d = FETCH;
         FETCH:   if (last_beat) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      req_ready_o = (state_q == IDLE);
      desc_re     = (state_q == IDLE) && req_valid_i;
      desc_we     = cfg_we_i && !cfg_sel_i && (state_q == IDLE) && !req_valid_i;
      pair_we     = cfg_we_i &&  cfg_sel_i && (state_q == IDLE) && !req_valid_i;
      cfg_err_d   = cfg_we_i && !((state_q == IDLE) && !req_valid_i);
      pair_raddr  = rd_addr_q;
      pair_re     = 1'b0;
      if (state_q == LOOKUP) begin
         pair_raddr = lk_base;
         pair_re    = (lk_num != '0);
      end else if (state_q == FETCH) begin
         pair_re    = (idx_q + 1'b1) < beats_q;
      end
   end

   always_comb begin
      tag_d = tag_q;  num_d = num_q;  beats_d = beats_q;  idx_d = idx_q;  rd_addr_d = rd_addr_q;
      out_valid_d = 1'b0;  out_sos_d = 1'b0;  out_eos_d = 1'b0;
      out_tag_d = '0;  out_num_d = '0;  out_ids_d = '0;
      case (state_q)
         IDLE: if (req_valid_i) tag_d = req_pe_tag_i;
         LOOKUP: begin
            num_d     = lk_num;
            beats_d   = lk_beats;
            idx_d     = '0;
            rd_addr_d = lk_base + 1'b1;
         end
         FETCH: begin
            out_valid_d = 1'b1;
            out_sos_d   = (idx_q == '0);
            out_eos_d   = last_beat;
            out_tag_d   = tag_q;
            out_num_d   = num_q;
            out_ids_d   = beat_ids;
            idx_d       = idx_q + 1'b1;
            rd_addr_d   = rd_addr_q + 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         tag_q <= '0;  num_q <= '0;  beats_q <= '0;  idx_q <= '0;  rd_addr_q <= '0;
         out_valid_q <= 1'b0;  out_sos_q <= 1'b0;  out_eos_q <= 1'b0;
         out_tag_q <= '0;  out_num_q <= '0;  out_ids_q <= '0;  cfg_err_q <= 1'b0;
      end else begin
         tag_q <= tag_d;  num_q <= num_d;  beats_q <= beats_d;  idx_q <= idx_d;
         rd_addr_q <= rd_addr_d;
         out_valid_q <= out_valid_d;  out_sos_q <= out_sos_d;  out_eos_q <= out_eos_d;
         out_tag_q <= out_tag_d;  out_num_q <= out_num_d;  out_ids_q <= out_ids_d;
         cfg_err_q <= cfg_err_d;
      end
   end

   assign out_valid_o  = out_valid_q;
   assign out_sos_o    = out_sos_q;
   assign out_eos_o    = out_eos_q;
   assign out_pe_tag_o = out_tag_q;
   assign out_num_o    = out_num_q;
   assign out_ids_o    = out_ids_q;
   assign cfg_err_o    = cfg_err_q;
endmodule
